// File: rtl/uart_tx_sched.sv
// ----------------------------------------------------------------------------
// uart_tx_sched
//   Schedules bytes from two sources onto a single UART byte transmitter:
//   decoded keyboard characters (buffered in a small FIFO) and a message
//   source that hands over multi-byte messages one byte at a time. A message
//   that has started is sent to completion before any key byte is granted;
//   otherwise the two sources are served round-robin, message first after
//   reset. Exactly one byte is in flight at a time.
//
// Ports
//   CLK100MHZ  in   system clock, rising edge
//   RST        in   synchronous active-high reset
//   key_valid  in   one-cycle pulse, key_ascii holds a new character
//   key_ascii  in   [7:0] character; 0x00 means unmapped and is ignored
//   msg_req    in   message source has a byte ready (held until msg_ack)
//   msg_data   in   [7:0] message byte
//   msg_last   in   msg_data is the final byte of its message
//   msg_ack    out  one-cycle pulse, message byte taken
//   tx_busy    in   UART transmitter busy
//   tx_start   out  one-cycle pulse, transmit tx_data
//   tx_data    out  [7:0] byte to transmit, held until the next grant
//   fifo_full  out  key FIFO holds FIFO_DEPTH characters
//   drop_cnt   out  [7:0] characters lost to a full FIFO, saturates at 255
// ----------------------------------------------------------------------------
module uart_tx_sched #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic       CLK100MHZ,
   input  logic       RST,
   input  logic       key_valid,
   input  logic [7:0] key_ascii,
   input  logic       msg_req,
   input  logic [7:0] msg_data,
   input  logic       msg_last,
   output logic       msg_ack,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic       fifo_full,
   output logic [7:0] drop_cnt
);

   localparam int            AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_ISSUE     = 2'd1;
   localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
   localparam logic [1:0] ST_WAIT_DONE = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [7:0]    fifo_mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          fifo_full_q, fifo_full_d;
   logic [7:0]    drop_cnt_q, drop_cnt_d;
   logic          lock_q, lock_d;          // mid-message: only msg may be granted
   logic          last_msg_q, last_msg_d;  // last grant went to msg requester
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_start_q, tx_start_d;
   logic          msg_ack_q, msg_ack_d;

   logic fifo_empty_s;
   logic push_req_s;
   logic push_ok_s;
   logic drop_s;
   logic grant_key_s;
   logic grant_msg_s;
   logic grant_s;

   assign fifo_empty_s = (count_q == CNT_ZERO);
   assign push_req_s   = key_valid && (key_ascii != 8'h00);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_ok_s    = push_req_s && (!fifo_full_q || grant_key_s);
   assign drop_s       = push_req_s && fifo_full_q && !grant_key_s;
   assign grant_s      = grant_key_s | grant_msg_s;

   // Arbitration: only from IDLE with the transmitter free.
   always_comb begin
      grant_key_s = 1'b0;
      grant_msg_s = 1'b0;
      if ((state_q == ST_IDLE) && !tx_busy) begin
         if (lock_q) begin
            // Keys wait even if msg_req drops mid-message.
            grant_msg_s = msg_req;
         end else if (msg_req && !fifo_empty_s) begin
            grant_key_s = last_msg_q;
            grant_msg_s = !last_msg_q;
         end else begin
            grant_msg_s = msg_req;
            grant_key_s = !fifo_empty_s;
         end
      end else begin
         grant_key_s = 1'b0;
         grant_msg_s = 1'b0;
      end
   end

   // Key FIFO pointers, occupancy and drop counter.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      drop_cnt_d = drop_cnt_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (grant_key_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, grant_key_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      if (drop_s && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
      fifo_full_d = (count_d == DEPTH_C);
   end

   // Transfer FSM, grant side effects and registered outputs.
   always_comb begin
      state_d    = state_q;
      lock_d     = lock_q;
      last_msg_d = last_msg_q;
      tx_data_d  = tx_data_q;
      // tx_start and msg_ack are both visible in the cycle after the grant
      // decision, i.e. together with the newly loaded tx_data.
      tx_start_d = grant_s;
      msg_ack_d  = grant_msg_s;
      if (grant_key_s) begin
         tx_data_d  = fifo_mem_q[rd_ptr_q];
         last_msg_d = 1'b0;
      end else if (grant_msg_s) begin
         tx_data_d  = msg_data;
         last_msg_d = 1'b1;
         lock_d     = !msg_last;
      end else begin
         tx_data_d  = tx_data_q;
      end
      case (state_q)
         ST_IDLE: begin
            if (grant_s) begin
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = ST_WAIT_DONE;
            end else begin
               state_d = ST_WAIT_BUSY;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FIFO storage; contents are don't-care while the pointers say empty.
   always_ff @(posedge CLK100MHZ) begin
      if (push_ok_s) begin
         fifo_mem_q[wr_ptr_q] <= key_ascii;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLK100MHZ) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= {AW{1'b0}};
         rd_ptr_q    <= {AW{1'b0}};
         count_q     <= CNT_ZERO;
         fifo_full_q <= 1'b0;
         drop_cnt_q  <= 8'h00;
         lock_q      <= 1'b0;
         last_msg_q  <= 1'b0;
         tx_data_q   <= 8'h00;
         tx_start_q  <= 1'b0;
         msg_ack_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         fifo_full_q <= fifo_full_d;
         drop_cnt_q  <= drop_cnt_d;
         lock_q      <= lock_d;
         last_msg_q  <= last_msg_d;
         tx_data_q   <= tx_data_d;
         tx_start_q  <= tx_start_d;
         msg_ack_q   <= msg_ack_d;
      end
   end

   assign msg_ack   = msg_ack_q;
   assign tx_start  = tx_start_q;
   assign tx_data   = tx_data_q;
   assign fifo_full = fifo_full_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_sched
//   Directed scenarios plus a randomized run against a queue-based reference
//   model. Environment: a UART transmitter that goes busy the cycle after
//   tx_start for busy_len cycles (or while busy_hold), and a message source
//   that holds each byte until msg_ack, optionally pausing between bytes.
// ----------------------------------------------------------------------------
module tb_uart_tx_sched;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_valid;
   logic [7:0] key_ascii;
   logic       msg_req;
   logic [7:0] msg_data;
   logic       msg_last;
   logic       msg_ack;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       fifo_full;
   logic [7:0] drop_cnt;

   int n_tests;
   int n_fail;

   // environment state
   int         busy_cnt;
   int         busy_len;
   bit         busy_hold;
   logic [8:0] src_q[$];      // {last, data}
   int         src_gap;
   int         src_gap_lo;
   int         src_gap_hi;
   logic [7:0] got_q[$];      // bytes seen on tx_start
   int         ack_cnt;

   // reference model state
   logic [7:0] mq[$];
   bit         m_out;
   bit         m_issued;
   bit         m_seen;
   bit         m_lock;
   bit         m_last_msg;
   int         m_drops;
   logic       e_start;
   logic       e_ack;
   logic       e_full;
   logic [7:0] e_data;
   logic [7:0] e_drop;

   uart_tx_sched #(.FIFO_DEPTH(DEPTH)) dut (
      .CLK100MHZ (clk),
      .RST       (rst),
      .key_valid (key_valid),
      .key_ascii (key_ascii),
      .msg_req   (msg_req),
      .msg_data  (msg_data),
      .msg_last  (msg_last),
      .msg_ack   (msg_ack),
      .tx_busy   (tx_busy),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .fifo_full (fifo_full),
      .drop_cnt  (drop_cnt)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // global time limit
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic src_drive();
      if ((src_q.size() > 0) && (src_gap == 0)) begin
         msg_req  = 1'b1;
         msg_data = src_q[0][7:0];
         msg_last = src_q[0][8];
      end else begin
         msg_req  = 1'b0;
         msg_data = 8'h00;
         msg_last = 1'b0;
      end
   endtask

   // Reference model: what the coming clock edge does, from the rules.
   task automatic model_edge();
      bit g_key;
      bit g_msg;
      bit keys_ok;
      if (rst) begin
         mq.delete();
         m_out = 0; m_issued = 0; m_seen = 0; m_lock = 0; m_last_msg = 0;
         m_drops = 0;
         e_start = 1'b0; e_ack = 1'b0; e_full = 1'b0; e_data = 8'h00; e_drop = 8'h00;
         return;
      end
      g_key   = 0;
      g_msg   = 0;
      keys_ok = (mq.size() != 0) && !m_lock;
      if (!m_out && !tx_busy) begin
         if (msg_req && keys_ok) begin
            if (m_last_msg) g_key = 1; else g_msg = 1;
         end else if (msg_req) begin
            g_msg = 1;
         end else if (keys_ok) begin
            g_key = 1;
         end
      end
      // one byte outstanding: start pulse, transmitter busy, transmitter free
      if (m_out) begin
         if (!m_issued) m_issued = 1;
         else if (!m_seen) m_seen = tx_busy;
         else if (!tx_busy) m_out = 0;
      end
      if (g_key) begin
         e_data = mq.pop_front();
         m_last_msg = 0;
      end
      if (g_msg) begin
         e_data = msg_data;
         m_last_msg = 1;
         m_lock = !msg_last;
      end
      if (g_key || g_msg) begin
         m_out = 1; m_issued = 0; m_seen = 0;
      end
      if (key_valid && (key_ascii != 8'h00)) begin
         if (mq.size() < DEPTH) mq.push_back(key_ascii);
         else if (m_drops < 255) m_drops++;
      end
      e_start = g_key | g_msg;
      e_ack   = g_msg;
      e_full  = (mq.size() == DEPTH);
      e_drop  = 8'(m_drops);
   endtask

   // One clock cycle; outputs are observed at the following falling edge.
   task automatic tick();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      key_valid = 1'b0;
      key_ascii = 8'h00;
      if (tx_start === 1'b1) begin
         got_q.push_back(tx_data);
         busy_cnt = busy_len;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
      end
      tx_busy = busy_hold || (busy_cnt > 0);
      if (msg_ack === 1'b1) begin
         ack_cnt++;
         if (src_q.size() > 0) void'(src_q.pop_front());
         src_gap = $urandom_range(src_gap_hi, src_gap_lo);
      end else if (src_gap > 0) begin
         src_gap--;
      end
      src_drive();
   endtask

   task automatic do_reset();
      busy_hold = 0; busy_cnt = 0; busy_len = 10;
      src_q.delete(); src_gap = 0; src_gap_lo = 0; src_gap_hi = 0;
      tx_busy = 1'b0; key_valid = 1'b0; key_ascii = 8'h00;
      src_drive();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      got_q.delete();
      ack_cnt = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_tx_start got %b exp 0", tx_start); end
      n_tests++; if (msg_ack !== 1'b0) begin n_fail++; $display("FAIL rst_msg_ack got %b exp 0", msg_ack); end
      n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data got %h exp 00", tx_data); end
      n_tests++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL rst_fifo_full got %b exp 0", fifo_full); end
      n_tests++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL rst_drop_cnt got %h exp 00", drop_cnt); end
   endtask

   task automatic test_key_latency();
      int extra;
      do_reset();
      key_valid = 1'b1; key_ascii = 8'h41;
      tick();
      n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL lat_n1_start got %b exp 0", tx_start); end
      tick();
      n_tests++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL lat_n2_start got %b exp 1", tx_start); end
      n_tests++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL lat_n2_data got %h exp 41", tx_data); end
      tick();
      n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL lat_pulse_len got %b exp 0", tx_start); end
      extra = got_q.size();
      repeat (20) tick();
      n_tests++; if (got_q.size() !== extra) begin n_fail++; $display("FAIL lat_extra_start got %0d exp %0d", got_q.size(), extra); end
      // back in IDLE: a second key shows the same latency
      key_valid = 1'b1; key_ascii = 8'h42;
      tick();
      tick();
      n_tests++; if ((tx_start !== 1'b1) || (tx_data !== 8'h42)) begin n_fail++; $display("FAIL lat_second got %b/%h exp 1/42", tx_start, tx_data); end
   endtask

   task automatic test_fifo_full_drop();
      logic [7:0] obs;
      do_reset();
      busy_hold = 1; tx_busy = 1'b1;
      for (int i = 0; i < 9; i++) begin
         key_valid = 1'b1; key_ascii = 8'(8'h31 + i);
         tick();
         if (i == 6) begin
            n_tests++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL ff_full_at7 got %b exp 0", fifo_full); end
         end
         if (i == 7) begin
            n_tests++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL ff_full_at8 got %b exp 1", fifo_full); end
            n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL ff_drop_at8 got %0d exp 0", drop_cnt); end
         end
         if (i == 8) begin
            n_tests++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL ff_drop_at9 got %0d exp 1", drop_cnt); end
         end
      end
      busy_hold = 0; tx_busy = 1'b0;
      repeat (200) tick();
      n_tests++; if (got_q.size() !== 8) begin n_fail++; $display("FAIL ff_count got %0d exp 8", got_q.size()); end
      for (int k = 0; k < 8; k++) begin
         obs = (k < got_q.size()) ? got_q[k] : 8'hxx;
         n_tests++; if (obs !== 8'(8'h31 + k)) begin n_fail++; $display("FAIL ff_order[%0d] got %h exp %h", k, obs, 8'(8'h31 + k)); end
      end
      n_tests++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL ff_drained got %b exp 0", fifo_full); end
   endtask

   task automatic test_zero_key_and_saturation();
      do_reset();
      key_valid = 1'b1; key_ascii = 8'h00;
      tick();
      repeat (20) tick();
      n_tests++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL zk_no_start got %0d exp 0", got_q.size()); end
      n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL zk_drop got %0d exp 0", drop_cnt); end
      busy_hold = 1; tx_busy = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         key_valid = 1'b1; key_ascii = 8'(8'h50 + i);
         tick();
      end
      key_valid = 1'b1; key_ascii = 8'h00;
      tick();
      n_tests++; if ((drop_cnt !== 8'd0) || (fifo_full !== 1'b1)) begin n_fail++; $display("FAIL zk_full_zero got drop %0d full %b exp 0/1", drop_cnt, fifo_full); end
      for (int i = 0; i < 260; i++) begin
         key_valid = 1'b1; key_ascii = 8'h7A;
         tick();
         if (i == 253) begin
            n_tests++; if (drop_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_254 got %0d exp 254", drop_cnt); end
         end
         if (i == 254) begin
            n_tests++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_255 got %0d exp 255", drop_cnt); end
         end
      end
      n_tests++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold got %0d exp 255", drop_cnt); end
   endtask

   task automatic test_msg_lock();
      logic [7:0] exp_seq[$];
      logic [7:0] obs;
      do_reset();
      busy_hold = 1; tx_busy = 1'b1;
      key_valid = 1'b1; key_ascii = 8'h61; tick();
      key_valid = 1'b1; key_ascii = 8'h62; tick();
      // source pauses 30 cycles after each byte: mid-message keys must wait
      src_gap_lo = 30; src_gap_hi = 30;
      src_q.push_back({1'b0, 8'h4F});
      src_q.push_back({1'b1, 8'h4B});
      src_drive();
      busy_hold = 0; tx_busy = 1'b0;
      repeat (250) tick();
      exp_seq = '{8'h4F, 8'h4B, 8'h61, 8'h62};
      n_tests++; if (got_q.size() !== exp_seq.size()) begin n_fail++; $display("FAIL lock_count got %0d exp %0d", got_q.size(), exp_seq.size()); end
      for (int k = 0; k < exp_seq.size(); k++) begin
         obs = (k < got_q.size()) ? got_q[k] : 8'hxx;
         n_tests++; if (obs !== exp_seq[k]) begin n_fail++; $display("FAIL lock_order[%0d] got %h exp %h", k, obs, exp_seq[k]); end
      end
      n_tests++; if (ack_cnt !== 2) begin n_fail++; $display("FAIL lock_acks got %0d exp 2", ack_cnt); end
   endtask

   task automatic test_alternation();
      logic [7:0] exp_seq[$];
      logic [7:0] obs;
      do_reset();
      busy_hold = 1; tx_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         key_valid = 1'b1; key_ascii = 8'(8'h71 + i);
         tick();
      end
      for (int i = 0; i < 3; i++) src_q.push_back({1'b1, 8'(8'hA1 + i)});
      src_drive();
      busy_hold = 0; tx_busy = 1'b0;
      repeat (250) tick();
      exp_seq = '{8'hA1, 8'h71, 8'hA2, 8'h72, 8'hA3, 8'h73};
      n_tests++; if (got_q.size() !== exp_seq.size()) begin n_fail++; $display("FAIL alt_count got %0d exp %0d", got_q.size(), exp_seq.size()); end
      for (int k = 0; k < exp_seq.size(); k++) begin
         obs = (k < got_q.size()) ? got_q[k] : 8'hxx;
         n_tests++; if (obs !== exp_seq[k]) begin n_fail++; $display("FAIL alt_order[%0d] got %h exp %h", k, obs, exp_seq[k]); end
      end
   endtask

   task automatic test_reset_mid_msg();
      logic [7:0] exp_seq[$];
      logic [7:0] obs;
      do_reset();
      busy_hold = 1; tx_busy = 1'b1;
      for (int i = 0; i < 9; i++) begin
         key_valid = 1'b1; key_ascii = 8'(8'h61 + i);
         tick();
      end
      src_q.push_back({1'b0, 8'h10});
      src_q.push_back({1'b0, 8'h11});
      src_q.push_back({1'b1, 8'h12});
      src_drive();
      busy_hold = 0; tx_busy = 1'b0;
      for (int k = 0; (k < 40) && (got_q.size() == 0); k++) tick();
      obs = (got_q.size() > 0) ? got_q[0] : 8'hxx;
      n_tests++; if (obs !== 8'h10) begin n_fail++; $display("FAIL rm_first got %h exp 10", obs); end
      repeat (4) tick();
      // transmitter still busy with 0x10, message locked
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++; if ((tx_start !== 1'b0) || (msg_ack !== 1'b0)) begin n_fail++; $display("FAIL rm_rst_pulses got %b/%b exp 0/0", tx_start, msg_ack); end
      n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rm_rst_data got %h exp 00", tx_data); end
      n_tests++; if ((fifo_full !== 1'b0) || (drop_cnt !== 8'h00)) begin n_fail++; $display("FAIL rm_rst_fifo got %b/%0d exp 0/0", fifo_full, drop_cnt); end
      got_q.delete();
      ack_cnt = 0;
      key_valid = 1'b1; key_ascii = 8'h41;
      repeat (3) tick();
      n_tests++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL rm_no_resume got %0d exp 0", got_q.size()); end
      repeat (200) tick();
      exp_seq = '{8'h11, 8'h12, 8'h41};
      n_tests++; if (got_q.size() !== exp_seq.size()) begin n_fail++; $display("FAIL rm_count got %0d exp %0d", got_q.size(), exp_seq.size()); end
      for (int k = 0; k < exp_seq.size(); k++) begin
         obs = (k < got_q.size()) ? got_q[k] : 8'hxx;
         n_tests++; if (obs !== exp_seq[k]) begin n_fail++; $display("FAIL rm_order[%0d] got %h exp %h", k, obs, exp_seq[k]); end
      end
      n_tests++; if (ack_cnt !== 2) begin n_fail++; $display("FAIL rm_acks got %0d exp 2", ack_cnt); end
   endtask

   task automatic test_random();
      int n;
      do_reset();
      src_gap_lo = 0; src_gap_hi = 4;
      for (int i = 0; i < 3000; i++) begin
         key_valid = ($urandom_range(3, 0) == 0);
         key_ascii = ($urandom_range(7, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
         busy_hold = (((i / 150) % 4) == 3);
         busy_len  = $urandom_range(12, 1);
         tx_busy   = busy_hold || (busy_cnt > 0);
         if ((src_q.size() == 0) && ($urandom_range(9, 0) == 0)) begin
            n = $urandom_range(3, 1);
            for (int j = 0; j < n; j++) src_q.push_back({(j == n - 1), 8'($urandom_range(255, 0))});
            src_drive();
         end
         tick();
         n_tests++;
         if ({tx_start, msg_ack, fifo_full} !== {e_start, e_ack, e_full}) begin
            n_fail++;
            $display("FAIL rnd_ctrl cycle %0d got start/ack/full %b%b%b exp %b%b%b", i, tx_start, msg_ack, fifo_full, e_start, e_ack, e_full);
         end
         n_tests++;
         if ({tx_data, drop_cnt} !== {e_data, e_drop}) begin
            n_fail++;
            $display("FAIL rnd_data cycle %0d got data %h drop %0d exp data %h drop %0d", i, tx_data, drop_cnt, e_data, e_drop);
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      key_valid = 1'b0; key_ascii = 8'h00;
      msg_req = 1'b0; msg_data = 8'h00; msg_last = 1'b0;
      tx_busy = 1'b0;
      busy_cnt = 0; busy_len = 10; busy_hold = 0;
      src_gap = 0; src_gap_lo = 0; src_gap_hi = 0; ack_cnt = 0;
      test_reset();
      test_key_latency();
      test_fifo_full_drop();
      test_zero_key_and_saturation();
      test_msg_lock();
      test_alternation();
      test_reset_mid_msg();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
